decode_stage: RTL and testbench

//  Registered, back-pressurable RISC-V decode stage that replaces the combinational decoder between fetch and issue.

---
 rtl/decode_stage_pkg.sv | 52 +++++
 rtl/decode_stage_if.sv | 48 ++++
 rtl/decode_stage_comb.sv | 141 ++++++++++++++
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core101_dec_pkg
// Description : Shared constants and types for the decode stage: major
//               opcodes (ins[6:2]), exec-unit select codes, micro-op codes
//               and the fixed-width control part of a decoded bundle.
// Revision    : 1.0  initial release
// ============================================================================
package core101_dec_pkg;

    // Major opcodes, ins[6:2] (ins[1:0] must be 2'b11)
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_OPV    = 5'b10101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // One-hot exec-unit select
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_ALU  = 3'b001;
    localparam logic [2:0] SEL_LSU  = 3'b010;
    localparam logic [2:0] SEL_VEC  = 3'b100;

    localparam logic [3:0] UOP_ADD  = 4'b0000;

    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    // Control fields of a decoded bundle; the XLEN-wide imm and pc travel
    // beside it. Field offsets follow from the packed declaration order
    // (illegal at bit 0, sel at the top).
    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] uop;
        logic       pc_mux;
        logic       imm_mux;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } dec_ctrl_t;

    localparam int CTRL_W = $bits(dec_ctrl_t);

endpackage : core101_dec_pkg
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : dec_fetch_if / dec_issue_if
// Description : Handshake bundles around the decode stage.
//               dec_fetch_if : fetch (master) -> decode (slave)
//                   ins_valid_in, ins_in[31:0], pc_in[XLEN-1:0], ins_ready_out
//               dec_issue_if : decode (master) -> issue (slave)
//                   dec_valid_out, dec_ready_in and the decoded fields
// Revision    : 1.0  initial release
// ============================================================================
interface dec_fetch_if #(
    parameter int XLEN = 32
);
    logic            ins_valid_in;
    logic [31:0]     ins_in;
    logic [XLEN-1:0] pc_in;
    logic            ins_ready_out;

    modport master (output ins_valid_in, ins_in, pc_in, input  ins_ready_out);
    modport slave  (input  ins_valid_in, ins_in, pc_in, output ins_ready_out);
endinterface : dec_fetch_if

interface dec_issue_if #(
    parameter int XLEN = 32
);
    logic            dec_valid_out;
    logic            dec_ready_in;
    logic [2:0]      exec_unit_sel_out;
    logic [3:0]      exec_unit_uop_out;
    logic            pc_mux_sel_out;
    logic            imm_mux_sel_out;
    logic [XLEN-1:0] imm_out;
    logic [4:0]      rs1_out;
    logic [4:0]      rs2_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] pc_out;
    logic            illegal_out;

    modport master (output dec_valid_out, exec_unit_sel_out, exec_unit_uop_out,
                           pc_mux_sel_out, imm_mux_sel_out, imm_out, rs1_out,
                           rs2_out, rd_out, pc_out, illegal_out,
                    input  dec_ready_in);
    modport slave  (input  dec_valid_out, exec_unit_sel_out, exec_unit_uop_out,
                           pc_mux_sel_out, imm_mux_sel_out, imm_out, rs1_out,
                           rs2_out, rd_out, pc_out, illegal_out,
                    output dec_ready_in);
endinterface : dec_issue_if
`default_nettype wire

// File: rtl/decode_stage_comb.sv
`default_nettype none
// ============================================================================
// Module      : decode_comb
// Description : Purely combinational RV32 decoder: raw instruction + PC in,
//               control fields, sign-extended immediate and PC out.
//   i_ins   [31:0]      raw instruction
//   i_pc    [XLEN-1:0]  instruction PC (passed through)
//   o_ctrl  dec_ctrl_t  sel/uop/mux selects/register indices/illegal
//   o_imm   [XLEN-1:0]  sign-extended immediate
//   o_pc    [XLEN-1:0]  PC of the bundle
// Revision    : 1.0  initial release
// ============================================================================
module decode_comb
    import core101_dec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int VEC_EN = 1
) (
    input  logic [31:0]     i_ins,
    input  logic [XLEN-1:0] i_pc,
    output dec_ctrl_t       o_ctrl,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_pc
);

    logic [4:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_imm32;
    logic        w_known;
    logic        w_bad_fn;
    logic        w_illegal;

    assign w_opc = i_ins[6:2];
    assign w_f3  = i_ins[14:12];
    assign w_f7  = i_ins[31:25];

    assign w_imm_i = {{20{i_ins[31]}}, i_ins[31:20]};
    assign w_imm_s = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
    assign w_imm_b = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
    assign w_imm_u = {i_ins[31:12], 12'b0};
    assign w_imm_j = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};

    always_comb begin
        o_ctrl   = '0;
        w_imm32  = '0;
        w_known  = 1'b1;
        w_bad_fn = 1'b0;

        case (w_opc)
            OPC_LOAD: begin
                o_ctrl.sel     = SEL_LSU;
                o_ctrl.uop     = {1'b0, w_f3};
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_i;
            end
            OPC_STORE: begin
                o_ctrl.sel     = SEL_LSU;
                o_ctrl.uop     = {1'b1, w_f3};
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_s;
            end
            OPC_OPIMM: begin
                o_ctrl.sel     = SEL_ALU;
                // f7[5] only distinguishes SRAI from SRLI; for every other
                // f3 those bits belong to the immediate.
                o_ctrl.uop     = {(w_f3 == 3'b101) ? w_f7[5] : 1'b0, w_f3};
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_i;
                w_bad_fn       = ((w_f3 == 3'b001) && (w_f7 != F7_ZERO)) ||
                                 ((w_f3 == 3'b101) && (w_f7 != F7_ZERO) && (w_f7 != F7_ALT));
            end
            OPC_OP: begin
                o_ctrl.sel = SEL_ALU;
                o_ctrl.uop = {w_f7[5], w_f3};
                w_bad_fn   = ((w_f7 != F7_ZERO) && (w_f7 != F7_ALT)) ||
                             ((w_f7 == F7_ALT) && (w_f3 != 3'b000) && (w_f3 != 3'b101));
            end
            OPC_LUI: begin
                o_ctrl.sel     = SEL_ALU;
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_u;
            end
            OPC_AUIPC: begin
                o_ctrl.sel     = SEL_ALU;
                o_ctrl.pc_mux  = 1'b1;
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_u;
            end
            OPC_JAL: begin
                o_ctrl.sel     = SEL_ALU;
                o_ctrl.pc_mux  = 1'b1;
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_j;
            end
            OPC_JALR: begin
                o_ctrl.sel     = SEL_ALU;
                o_ctrl.pc_mux  = 1'b1;
                o_ctrl.imm_mux = 1'b1;
                w_imm32        = w_imm_i;
            end
            OPC_BRANCH: begin
                o_ctrl.sel    = SEL_ALU;
                o_ctrl.uop    = {1'b1, w_f3};
                o_ctrl.pc_mux = 1'b1;
                w_imm32       = w_imm_b;
            end
            OPC_SYSTEM: begin
                // Legal but handled outside the exec units.
            end
            OPC_OPV: begin
                o_ctrl.sel = SEL_VEC;
                o_ctrl.uop = {1'b0, w_f3};
                w_bad_fn   = (VEC_EN == 0);
            end
            default: w_known = 1'b0;
        endcase

        w_illegal = (i_ins[1:0] != 2'b11) || !w_known || w_bad_fn;

        // Illegal bundles still flow downstream but must not steer any unit.
        if (w_illegal) begin
            o_ctrl.sel     = SEL_NONE;
            o_ctrl.uop     = UOP_ADD;
            o_ctrl.pc_mux  = 1'b0;
            o_ctrl.imm_mux = 1'b0;
            w_imm32        = '0;
        end

        o_ctrl.rs1     = i_ins[19:15];
        o_ctrl.rs2     = i_ins[24:20];
        o_ctrl.rd      = i_ins[11:7];
        o_ctrl.illegal = w_illegal;
    end

    assign o_imm = XLEN'($signed(w_imm32));
    assign o_pc  = i_pc;

endmodule : decode_comb
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered, back-pressurable decode stage between fetch and
//               issue. Decodes at the input, stores the decoded bundle in an
//               output register plus an optional skid register, supports
//               flush, and counts retired illegal bundles (saturating).
//   clock_in, reset_in (sync, active-high), flush_in
//   i_fetch            dec_fetch_if.slave  : valid/ready, ins, pc
//   o_issue            dec_issue_if.master : valid/ready, decoded fields
//   illegal_count_out  [CNT_W-1:0]         : illegal bundles retired
// Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import core101_dec_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int VEC_EN  = 1,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  wire logic             clock_in,
    input  wire logic             reset_in,
    input  wire logic             flush_in,
    dec_fetch_if.slave            i_fetch,
    dec_issue_if.master           o_issue,
    output logic [CNT_W-1:0]      illegal_count_out
);

    typedef struct packed {
        dec_ctrl_t       ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } bundle_t;

    bundle_t          w_dec;
    bundle_t          r_out;
    logic             r_out_valid;
    bundle_t          w_skid;
    logic             w_skid_valid;
    logic             w_ins_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_out_free;
    logic [CNT_W-1:0] r_cnt;

    decode_comb #(
        .XLEN   (XLEN),
        .VEC_EN (VEC_EN)
    ) u_decode_comb (
        .i_ins  (i_fetch.ins_in),
        .i_pc   (i_fetch.pc_in),
        .o_ctrl (w_dec.ctrl),
        .o_imm  (w_dec.imm),
        .o_pc   (w_dec.pc)
    );

    assign w_in_xfer  = i_fetch.ins_valid_in && w_ins_ready;
    assign w_out_xfer = r_out_valid && o_issue.dec_ready_in;
    // Output register can take a new bundle at the coming edge.
    assign w_out_free = !r_out_valid || w_out_xfer;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic    r_skid_valid;
            bundle_t r_skid;

            // The skid only fills while the output is stalled; whenever the
            // output is free the skid content (if any) moves into it, so the
            // skid empties on that same edge.
            always_ff @(posedge clock_in) begin
                if (reset_in) begin
                    r_skid_valid <= 1'b0;
                    r_skid       <= '0;
                end else if (flush_in) begin
                    r_skid_valid <= 1'b0;
                end else if (w_out_free) begin
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_skid_valid <= 1'b1;
                    r_skid       <= w_dec;
                end
            end

            assign w_skid_valid = r_skid_valid;
            assign w_skid       = r_skid;
            // Registered ready: room exists as long as the skid is empty.
            assign w_ins_ready  = !r_skid_valid;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid       = '0;
            assign w_ins_ready  = w_out_free;
        end
    endgenerate

    // Output register; fields are only rewritten on a load, so they hold
    // steady while issue stalls.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (flush_in) begin
            r_out_valid <= 1'b0;
        end else if (w_out_free) begin
            if (w_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out       <= w_skid;
            end else if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out       <= w_dec;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // A bundle leaving under flush is treated as discarded, not retired.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_cnt <= '0;
        end else if (w_out_xfer && !flush_in && r_out.ctrl.illegal &&
                     (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign i_fetch.ins_ready_out     = w_ins_ready;
    assign o_issue.dec_valid_out     = r_out_valid;
    assign o_issue.exec_unit_sel_out = r_out.ctrl.sel;
    assign o_issue.exec_unit_uop_out = r_out.ctrl.uop;
    assign o_issue.pc_mux_sel_out    = r_out.ctrl.pc_mux;
    assign o_issue.imm_mux_sel_out   = r_out.ctrl.imm_mux;
    assign o_issue.imm_out           = r_out.imm;
    assign o_issue.rs1_out           = r_out.ctrl.rs1;
    assign o_issue.rs2_out           = r_out.ctrl.rs2;
    assign o_issue.rd_out            = r_out.ctrl.rd;
    assign o_issue.pc_out            = r_out.pc;
    assign o_issue.illegal_out       = r_out.ctrl.illegal;
    assign illegal_count_out         = r_cnt;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed, scoreboard-based bench for decode_stage
//               (XLEN=32, VEC_EN=0, SKID_EN=1, CNT_W=2).
// Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    typedef struct packed {
        logic [2:0]  sel;
        logic [3:0]  uop;
        logic        pcm;
        logic        immm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] cnt;
    int         checks   = 0;
    int         failures = 0;
    exp_t       exp_q[$];

    always #5 clk = ~clk;

    dec_fetch_if #(.XLEN(32)) fetch ();
    dec_issue_if #(.XLEN(32)) issue ();

    decode_stage #(
        .XLEN    (32),
        .VEC_EN  (0),
        .SKID_EN (1),
        .CNT_W   (2)
    ) dut (
        .clock_in          (clk),
        .reset_in          (rst),
        .flush_in          (flush),
        .i_fetch           (fetch),
        .o_issue           (issue),
        .illegal_count_out (cnt)
    );

    function automatic exp_t mk(input logic [2:0] sel, input logic [3:0] uop,
                                input logic pcm, input logic immm,
                                input logic [31:0] imm, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] pc, input logic ill);
        exp_t e;
        e.sel = sel; e.uop = uop; e.pcm = pcm; e.immm = immm; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t obs_bundle();
        return mk(issue.exec_unit_sel_out, issue.exec_unit_uop_out,
                  issue.pc_mux_sel_out, issue.imm_mux_sel_out, issue.imm_out,
                  issue.rs1_out, issue.rs2_out, issue.rd_out, issue.pc_out,
                  issue.illegal_out);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // addi xN, x0, N
    function automatic logic [31:0] addi_n(input int n);
        logic [11:0] imm12;
        logic [4:0]  r5;
        imm12 = 12'(n);
        r5    = 5'(n);
        return {imm12, 5'd0, 3'b000, r5, 7'h13};
    endfunction

    function automatic exp_t addi_exp(input int n, input logic [31:0] pc);
        return mk(3'b001, 4'b0000, 1'b0, 1'b1, 32'(n), 5'd0, 5'(n), 5'(n), pc, 1'b0);
    endfunction

    // Scoreboard consumer: every out-transfer pops and compares one bundle.
    always @(negedge clk) begin
        if (!rst && !flush && issue.dec_valid_out && issue.dec_ready_in) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed_pc=%0h expected=none", issue.pc_out);
            end
            if (exp_q.size() > 0) chk("sb_bundle", 128'(obs_bundle()), 128'(exp_q.pop_front()));
        end
    end

    // Offer one instruction until accepted; the expectation is queued at acceptance.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        bit acc;
        acc = 1'b0;
        fetch.ins_valid_in = 1'b1;
        fetch.ins_in       = ins;
        fetch.pc_in        = pc;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (fetch.ins_ready_out) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        fetch.ins_valid_in = 1'b0;
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL send_timeout observed=not_accepted expected=accepted ins=%0h", ins);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        exp_t sexp[4];

        rst   = 1'b1;
        flush = 1'b0;
        fetch.ins_valid_in = 1'b0;
        fetch.ins_in       = '0;
        fetch.pc_in        = '0;
        issue.dec_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_valid",  128'(issue.dec_valid_out), 128'(0));
        chk("rst_ready",  128'(fetch.ins_ready_out), 128'(1));
        chk("rst_count",  128'(cnt), 128'(0));
        chk("rst_bundle", 128'(obs_bundle()), 128'(0));

        // addi x1,x0,-1 : visible the cycle after acceptance
        send(32'hFFF00093, 32'h100,
             mk(3'b001, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1, 32'h100, 1'b0));
        chk("latency_valid", 128'(issue.dec_valid_out), 128'(1));
        @(posedge clk); #1;

        // Legal patterns, back to back
        send(32'h402081B3, 32'h104,   // sub x3,x1,x2
             mk(3'b001, 4'b1000, 1'b0, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3, 32'h104, 1'b0));
        send(32'h0020A423, 32'h108,   // sw x2,8(x1)
             mk(3'b010, 4'b1010, 1'b0, 1'b1, 32'h8, 5'd1, 5'd2, 5'd8, 32'h108, 1'b0));
        send(32'hFFDFF06F, 32'h10C,   // jal x0,-4
             mk(3'b001, 4'b0000, 1'b1, 1'b1, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd0, 32'h10C, 1'b0));
        send(32'h123452B7, 32'h110,   // lui x5,0x12345
             mk(3'b001, 4'b0000, 1'b0, 1'b1, 32'h12345000, 5'd8, 5'd3, 5'd5, 32'h110, 1'b0));
        send(32'h40325213, 32'h114,   // srai x4,x4,3
             mk(3'b001, 4'b1101, 1'b0, 1'b1, 32'h403, 5'd4, 5'd3, 5'd4, 32'h114, 1'b0));
        send(32'h00208463, 32'h118,   // beq x1,x2,+8
             mk(3'b001, 4'b1000, 1'b1, 1'b0, 32'h8, 5'd1, 5'd2, 5'd8, 32'h118, 1'b0));
        repeat (2) @(posedge clk); #1;
        chk("legal_count", 128'(cnt), 128'(0));

        // Skid: stream 4, issue stalled for the first 3 cycles
        for (int i = 0; i < 4; i++) sexp[i] = addi_exp(i + 1, 32'h200 + 32'(4 * i));
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 4; cyc++) begin
            fetch.ins_valid_in = 1'b1;
            fetch.ins_in       = addi_n(idx + 1);
            fetch.pc_in        = 32'h200 + 32'(4 * idx);
            issue.dec_ready_in = (cyc >= 3);
            @(negedge clk);
            if (cyc == 1) chk("skid_room_ready", 128'(fetch.ins_ready_out), 128'(1));
            if (cyc == 2) begin
                chk("skid_full_ready", 128'(fetch.ins_ready_out), 128'(0));
                chk("hold_stable", 128'(obs_bundle()), 128'(sexp[0]));
            end
            if (fetch.ins_ready_out) begin
                exp_q.push_back(sexp[idx]);
                idx++;
            end
            @(posedge clk); #1;
        end
        fetch.ins_valid_in = 1'b0;
        chk("skid_all_sent", 128'(idx), 128'(4));
        repeat (4) @(posedge clk); #1;
        chk("skid_drained", 128'(exp_q.size()), 128'(0));

        // Flush with both registers full and a same-cycle input offer
        issue.dec_ready_in = 1'b0;
        send(addi_n(5), 32'h300, addi_exp(5, 32'h300));
        send(32'h00000000, 32'h304,
             mk(3'b000, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h304, 1'b1));
        chk("both_full_ready", 128'(fetch.ins_ready_out), 128'(0));
        fetch.ins_valid_in = 1'b1;
        fetch.ins_in       = addi_n(9);
        fetch.pc_in        = 32'h308;
        flush              = 1'b1;
        @(posedge clk); #1;
        flush              = 1'b0;
        fetch.ins_valid_in = 1'b0;
        exp_q.delete();
        chk("flush_valid", 128'(issue.dec_valid_out), 128'(0));
        chk("flush_ready", 128'(fetch.ins_ready_out), 128'(1));
        chk("flush_count", 128'(cnt), 128'(0));

        // Flush drops an input that would otherwise be accepted this cycle
        send(addi_n(6), 32'h310, addi_exp(6, 32'h310));
        fetch.ins_valid_in = 1'b1;
        fetch.ins_in       = addi_n(7);
        fetch.pc_in        = 32'h314;
        flush              = 1'b1;
        @(posedge clk); #1;
        flush              = 1'b0;
        fetch.ins_valid_in = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("flush_drop_valid", 128'(issue.dec_valid_out), 128'(0));
        issue.dec_ready_in = 1'b1;
        send(addi_n(8), 32'h318, addi_exp(8, 32'h318));
        repeat (2) @(posedge clk); #1;
        chk("post_flush_count", 128'(cnt), 128'(0));

        // Illegal bundles and counter saturation (CNT_W=2)
        send(32'h00000000, 32'h400,
             mk(3'b000, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h400, 1'b1));
        repeat (2) @(posedge clk); #1;
        chk("ill_count_1", 128'(cnt), 128'(1));
        send(32'h00000057, 32'h404,   // OP-V with VEC_EN=0
             mk(3'b000, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h404, 1'b1));
        repeat (2) @(posedge clk); #1;
        chk("ill_count_2", 128'(cnt), 128'(2));
        send(32'h023100B3, 32'h408,   // OP with f7=0000001
             mk(3'b000, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd2, 5'd3, 5'd1, 32'h408, 1'b1));
        repeat (2) @(posedge clk); #1;
        chk("ill_count_3", 128'(cnt), 128'(3));
        send(32'h0000007F, 32'h40C,   // unknown opcode
             mk(3'b000, 4'b0000, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h40C, 1'b1));
        repeat (2) @(posedge clk); #1;
        chk("ill_count_sat", 128'(cnt), 128'(3));

        repeat (3) @(posedge clk); #1;
        chk("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
